io_stream_write_array: RTL and testbench
========================================

# io_stream_write_array

Stream-to-memory sink: consumes words from an input stream and writes them to consecutive addresses of an attached array, starting at address 0, until a requested length has been stored. It then reports the number of words written through the standard sync handshake. It is the write-side counterpart of the stream-from-array reader. It sits between a stream producer and an `array` instance, and the `array` write port is driven only by this block.

## Interface
Parameters:
- `intN`, 8, data word width.
- `addrN`, 8, array address width; capacity is 2**addrN words.

Ports:
- `clk`  in  1  clock, rising edge.
- `nrst`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  request valid; `len` is sampled when `in_valid & in_ready`.
- `in_ready`  out  1  block idle and able to accept a request.
- `out_valid`  out  1  result valid; `count` is stable while high.
- `out_ready`  in  1  consumer accepts the result.
- `len`  in  addrN+1  number of words to write, 0..2**addrN.
- `sIn`  in  intN  input stream data.
- `sIn_valid`  in  1  input stream data valid.
- `sIn_ready`  out  1  block accepts `sIn` this cycle.
- `arr_addr`  out  addrN  write address.
- `arr_di`  out  intN  write data.
- `arr_we`  out  1  write enable; equal to `arr_valid`.
- `arr_valid`  out  1  a write is pending.
- `arr_ready`  in  1  the array commits the write this cycle.
- `count`  out  addrN+1  number of words written, valid with `out_valid`.

## Operation
- FSM states:
  - IDLE: `in_ready`=1.
  - RUN: words are accepted and written.
  - DONE: `out_valid`=1.
- IDLE → RUN on `in_valid & in_ready` with `len`≠0. On entry, `remaining`←`len`, `written`←0, `arr_addr`←0.
- IDLE → DONE on accept with `len`=0. No writes are issued; `count`=0.
- Write buffer: a one-entry hold register (`hold_valid`, `hold_data`).
  - `sIn_ready` = RUN & (`remaining`≠0) & (!`hold_valid` | `arr_ready`).
  - On `sIn_valid & sIn_ready`: load `hold_data`←`sIn`, set `hold_valid`, decrement `remaining`.
  - `arr_valid` = `arr_we` = `hold_valid`; `arr_di` = `hold_data`.
- On `arr_valid & arr_ready`: increment `arr_addr` and `written`. `hold_valid` clears unless it is refilled the same cycle.
- RUN → DONE when a commit makes `written`=`len`. `hold_valid` is then necessarily 0.
- DONE: `count`=`written`, held until `out_ready`. DONE → IDLE on `out_ready`.
- `in_valid` outside IDLE is ignored. `sIn` outside RUN is not consumed.

## Timing
- All outputs are registered or decoded from registered state only; there is no combinational path from `arr_ready`/`sIn_valid` to any output except `sIn_ready` (from `arr_ready`).
- Reset values, while `nrst`=0 and immediately after release:
  - state IDLE; `in_ready`=1 after release, 0 while asserted.
  - `out_valid`=0, `sIn_ready`=0, `arr_valid`=`arr_we`=0.
  - `arr_addr`=0, `arr_di`=0, `count`=0.
- Latency:
  - A word accepted at edge t is presented on `arr_di` in cycle t+1.
  - Full throughput is 1 word/cycle with `arr_ready` held at 1.
  - A `len`=N request with no stalls reaches `out_valid` N+2 cycles after acceptance.
- `arr_ready`=0 stalls: `hold_data`/`arr_addr` are held and `sIn_ready`=0. No word is dropped or duplicated.
- `len`=2**addrN: `arr_addr` reaches 2**addrN−1 on the last write, then wraps to 0 on commit; `count`=2**addrN (MSB set).
- `out_ready` and `in_valid` high in the same DONE cycle: the block returns to IDLE only; the new request is accepted no earlier than the next cycle.
- `nrst` asserted mid-RUN: the pending write is dropped immediately (`arr_we`=0 asynchronously), all state is cleared, and no partial `count` is reported.

## Structure
- `intN`/`addrN` defaults and the sync/stream/Array port macros come from the shared `primitives.v`.
- State encodings are local parameters of this module and are not shared.
- One natural sub-module is `stream_hold_reg`: a one-entry valid/data register with load/drain and the ready equation. It is reusable by other stream sinks.
- Expected size: 150–250 lines.

## Test plan
- Reset then `len`=16, `sIn`=0..15 continuous, `arr_ready`=1 → 16 writes at addrs 0..15 with data 0..15; `out_valid` at cycle 18; `count`=16.
- `len`=0 → no `arr_we` pulse; `out_valid` next cycle; `count`=0; returns to IDLE after `out_ready`.
- `len`=8, `arr_ready` toggling 1/0 every cycle, `sIn_valid` random → array contents 0..7 in order, no duplicates; `sIn_ready` low in every stalled cycle.
- `len`=256 with `addrN`=8 → 256 writes; last at addr 255 with data 255 mod 2**intN; `count`=256; `arr_addr`=0 afterwards.
- `nrst` pulsed low after 5 of 10 words → `arr_we`=0 immediately, `out_valid` never asserted; a new `len`=3 request then writes addrs 0..2 correctly.
- `out_valid` held with `out_ready`=0 for 10 cycles → `count` stable, `in_ready`=0, `sIn_ready`=0 throughout.

Source files
------------

// File: rtl/io_stream_write_array_pkg.sv
// -----------------------------------------------------------------------------
// io_stream_write_array_pkg
// Shared defaults for the stream-to-array writer and its helpers.
//   INT_N  : default data word width
//   ADDR_N : default array address width (capacity 2**ADDR_N words)
// -----------------------------------------------------------------------------
package io_stream_write_array_pkg;

    localparam int INT_N  = 8;
    localparam int ADDR_N = 8;

endpackage : io_stream_write_array_pkg

// File: rtl/io_stream_write_array_if.sv
// -----------------------------------------------------------------------------
// io_stream_write_array_if
// Bundles the three handshakes of the stream-to-array writer:
//   request/result sync : in_valid/in_ready/len, out_valid/out_ready/count
//   input stream        : sIn/sIn_valid/sIn_ready
//   array write port    : arr_addr/arr_di/arr_we/arr_valid/arr_ready
// Modports:
//   master : the environment (request issuer, stream producer, array)
//   slave  : the writer block itself
// -----------------------------------------------------------------------------
interface io_stream_write_array_if
    import io_stream_write_array_pkg::*;
#(
    parameter int intN  = INT_N,
    parameter int addrN = ADDR_N
);

    logic             in_valid;
    logic             in_ready;
    logic [addrN:0]   len;
    logic             out_valid;
    logic             out_ready;
    logic [addrN:0]   count;

    logic [intN-1:0]  sIn;
    logic             sIn_valid;
    logic             sIn_ready;

    logic [addrN-1:0] arr_addr;
    logic [intN-1:0]  arr_di;
    logic             arr_we;
    logic             arr_valid;
    logic             arr_ready;

    modport master (
        output in_valid, len, out_ready, sIn, sIn_valid, arr_ready,
        input  in_ready, out_valid, count, sIn_ready,
               arr_addr, arr_di, arr_we, arr_valid
    );

    modport slave (
        input  in_valid, len, out_ready, sIn, sIn_valid, arr_ready,
        output in_ready, out_valid, count, sIn_ready,
               arr_addr, arr_di, arr_we, arr_valid
    );

endinterface : io_stream_write_array_if

// File: rtl/io_stream_write_array_hold.sv
// -----------------------------------------------------------------------------
// io_stream_write_array_hold
// One-entry valid/data hold register for stream sinks. A word is loaded when
// the upstream handshake fires and drained when the downstream side accepts
// it; a drain and a load in the same cycle keep the entry full.
// Ports:
//   clk, nrst        : clock, asynchronous active-low reset
//   en               : sink is allowed to take more words
//   s_data/s_valid   : upstream word and valid
//   s_ready          : upstream ready (combinational from en/h_valid/drain)
//   drain            : downstream accepts the held word this cycle
//   h_valid/h_data   : held entry
// -----------------------------------------------------------------------------
module io_stream_write_array_hold
    import io_stream_write_array_pkg::*;
#(
    parameter int W = INT_N
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         en,
    input  logic [W-1:0] s_data,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic         drain,
    output logic         h_valid,
    output logic [W-1:0] h_data
);

    logic load;

    // A full entry can take a new word only in the cycle it is being drained.
    assign s_ready = en && (!h_valid || drain);
    assign load    = s_valid && s_ready;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            h_valid <= 1'b0;
            // NOTE: the data register is reset because it drives the array
            // data bus directly and must read 0 out of reset.
            h_data  <= '0;
        end else if (load) begin
            h_valid <= 1'b1;
            h_data  <= s_data;
        end else if (drain) begin
            h_valid <= 1'b0;
        end
    end

endmodule : io_stream_write_array_hold

// File: rtl/io_stream_write_array.sv
// -----------------------------------------------------------------------------
// io_stream_write_array
// Stream-to-memory sink. Accepts a length request, then writes that many
// stream words to consecutive array addresses starting at 0, and finally
// reports the number of words written on the result handshake.
// Ports:
//   clk, nrst : clock (rising edge), asynchronous active-low reset
//   bus       : slave side of io_stream_write_array_if (request/result,
//               input stream, array write port)
// -----------------------------------------------------------------------------
module io_stream_write_array
    import io_stream_write_array_pkg::*;
#(
    parameter int intN  = INT_N,
    parameter int addrN = ADDR_N
) (
    input  logic                     clk,
    input  logic                     nrst,
    io_stream_write_array_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [addrN:0] CNT_ZERO = '0;
    localparam logic [addrN:0] CNT_ONE  = 1;

    state_t           state, state_nx;
    logic [addrN:0]   remaining;   // words still to be taken from the stream
    logic [addrN:0]   written;     // words committed to the array
    logic [addrN:0]   len_q;
    logic [addrN-1:0] addr_q;

    logic             accept;
    logic             commit;
    logic             load;
    logic             hold_en;
    logic             hold_valid;
    logic [intN-1:0]  hold_data;
    logic [addrN:0]   written_inc;

    // in_ready is qualified by nrst so the block never advertises readiness
    // while it is held in reset.
    assign bus.in_ready  = (state == ST_IDLE) && nrst;
    assign bus.out_valid = (state == ST_DONE);
    assign bus.count     = written;

    assign accept      = bus.in_valid && bus.in_ready;
    assign commit      = hold_valid && bus.arr_ready;
    assign load        = bus.sIn_valid && bus.sIn_ready;
    assign hold_en     = (state == ST_RUN) && (remaining != CNT_ZERO);
    assign written_inc = written + CNT_ONE;

    io_stream_write_array_hold #(
        .W (intN)
    ) u_hold (
        .clk     (clk),
        .nrst    (nrst),
        .en      (hold_en),
        .s_data  (bus.sIn),
        .s_valid (bus.sIn_valid),
        .s_ready (bus.sIn_ready),
        .drain   (bus.arr_ready),
        .h_valid (hold_valid),
        .h_data  (hold_data)
    );

    assign bus.arr_valid = hold_valid;
    assign bus.arr_we    = hold_valid;
    assign bus.arr_di    = hold_data;
    assign bus.arr_addr  = addr_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state <= ST_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        // NOTE: next state defaults to the current state so no path through
        // the case leaves it unassigned (which would infer a latch).
        state_nx = state;
        unique case (state)
            ST_IDLE: if (accept) state_nx = (bus.len == CNT_ZERO) ? ST_DONE : ST_RUN;
            // The final commit is the only way out of RUN; by then every
            // accepted word has drained, so the hold entry is empty.
            ST_RUN:  if (commit && (written_inc == len_q)) state_nx = ST_DONE;
            ST_DONE: if (bus.out_ready) state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            remaining <= '0;
            written   <= '0;
            len_q     <= '0;
            addr_q    <= '0;
        end else if (accept) begin
            remaining <= bus.len;
            written   <= '0;
            len_q     <= bus.len;
            addr_q    <= '0;
        end else begin
            if (load) remaining <= remaining - CNT_ONE;
            // addr_q wraps naturally after the last address of a full array.
            if (commit) begin
                addr_q  <= addr_q + 1'b1;
                written <= written_inc;
            end
        end
    end

endmodule : io_stream_write_array

// File: tb/tb_io_stream_write_array.sv
// -----------------------------------------------------------------------------
// tb_io_stream_write_array
// Randomized scoreboard bench. The stimulus side pushes the expected array
// writes (address k gets the k-th stream word) and the expected count for
// each request; a monitor pops and compares on every committed write and on
// every result handshake.
// -----------------------------------------------------------------------------
module tb_io_stream_write_array;

    localparam int IN = 8;
    localparam int AN = 8;

    typedef struct packed {
        logic [AN-1:0] addr;
        logic [IN-1:0] data;
    } wr_t;

    logic clk;
    logic nrst;

    io_stream_write_array_if #(.intN(IN), .addrN(AN)) bus ();

    io_stream_write_array #(.intN(IN), .addrN(AN)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    int   vectors    = 0;
    int   miscompares = 0;
    int   cyc        = 0;
    int   acc_cyc    = 0;
    int   last_lat   = -1;
    logic prev_ov    = 1'b0;
    int   arr_mode   = 0;   // 0: ready=1, 1: toggle, 2: random, 3: ready=0

    wr_t  exp_wr[$];
    int   exp_cnt[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Array-side ready generator.
    initial begin
        bus.arr_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (arr_mode)
                0:       bus.arr_ready = 1'b1;
                1:       bus.arr_ready = !bus.arr_ready;
                2:       bus.arr_ready = ($urandom_range(0, 2) != 0);
                default: bus.arr_ready = 1'b0;
            endcase
        end
    end

    // Monitor: scoreboard pops, stall rule and latency measurement.
    initial forever begin
        @(negedge clk);
        if (nrst) begin
            check("arr_valid_eq_we", bus.arr_valid, bus.arr_we);
            if (bus.arr_we && bus.arr_ready) begin
                if (exp_wr.size() == 0) begin
                    check("unexpected_write", 1, 0);
                end else begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    check("write_addr", bus.arr_addr, e.addr);
                    check("write_data", bus.arr_di, e.data);
                end
            end
            if (bus.arr_we && !bus.arr_ready)
                check("stall_sin_ready", bus.sIn_ready, 0);
            if (bus.out_valid && bus.out_ready) begin
                if (exp_cnt.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    int c;
                    c = exp_cnt.pop_front();
                    check("count", bus.count, c);
                end
            end
            if (bus.in_valid && bus.in_ready) acc_cyc = cyc;
            if (bus.out_valid && !prev_ov) last_lat = cyc - acc_cyc;
            prev_ov = bus.out_valid;
        end else begin
            prev_ov = 1'b0;
        end
    end

    // Drives the stream words w[0..stop-1] in order; entered and left at
    // posedge+1.
    task automatic feed(input logic [IN-1:0] w[$], input bit burst, input int stop);
        int idx = 0;
        int k   = 0;
        while (idx < stop && k < 4000) begin
            bus.sIn_valid = burst || ($urandom_range(0, 3) != 0);
            bus.sIn       = w[idx];
            @(negedge clk);
            if (bus.sIn_valid && bus.sIn_ready) idx++;
            @(posedge clk);
            #1;
            k++;
        end
        bus.sIn_valid = 1'b0;
        if (idx < stop) check("feed_timeout", idx, stop);
    endtask

    // Issues a request with len=n and waits until it is accepted.
    task automatic issue(input int n);
        int k = 0;
        bus.len      = n[AN:0];
        bus.in_valid = 1'b1;
        do begin
            @(negedge clk);
            k++;
        end while (!bus.in_ready && k < 50);
        if (!bus.in_ready) check("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic run_req(input int n, input bit rnd_words, input int amode,
                           input bit burst, input int hold, input bit chk_lat,
                           input bit combo);
        logic [IN-1:0] w[$];
        int k = 0;
        for (int i = 0; i < n; i++) begin
            w.push_back(rnd_words ? IN'($urandom) : i[IN-1:0]);
            exp_wr.push_back('{addr: i[AN-1:0], data: w[i]});
        end
        exp_cnt.push_back(n);
        arr_mode = amode;
        issue(n);
        feed(w, burst, n);
        do begin
            @(negedge clk);
            k++;
        end while (!bus.out_valid && k < 3000);
        if (!bus.out_valid) begin
            check("done_timeout", 0, 1);
        end else begin
            if (chk_lat) begin
                #1;
                check("latency", last_lat, (n == 0) ? 1 : n + 2);
            end
            for (int h = 0; h < hold; h++) begin
                @(posedge clk);
                #1;
                @(negedge clk);
                check("hold_out_valid", bus.out_valid, 1);
                check("hold_count", bus.count, n);
                check("hold_in_ready", bus.in_ready, 0);
                check("hold_sin_ready", bus.sIn_ready, 0);
            end
            @(posedge clk);
            #1;
            bus.out_ready = 1'b1;
            if (combo) begin
                bus.in_valid = 1'b1;
                bus.len      = 9'd5;
            end
            @(negedge clk);
            @(posedge clk);
            #1;
            bus.out_ready = 1'b0;
            bus.in_valid  = 1'b0;
            @(negedge clk);
            check("idle_in_ready", bus.in_ready, 1);
            check("idle_out_valid", bus.out_valid, 0);
            check("arr_addr_after", bus.arr_addr, n % (1 << AN));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic reset_mid_run();
        logic [IN-1:0] w[$];
        for (int i = 0; i < 10; i++) begin
            w.push_back(IN'($urandom));
            if (i < 5) exp_wr.push_back('{addr: i[AN-1:0], data: w[i]});
        end
        arr_mode = 0;
        issue(10);
        feed(w, 1'b1, 5);
        repeat (2) @(posedge clk);
        #1;
        check("partial_writes_done", exp_wr.size(), 0);
        arr_mode      = 3;
        bus.arr_ready = 1'b0;
        bus.sIn       = w[5];
        bus.sIn_valid = 1'b1;
        @(negedge clk);
        check("sixth_word_ready", bus.sIn_ready, 1);
        @(posedge clk);
        #1;
        bus.sIn_valid = 1'b0;
        @(negedge clk);
        check("pending_write", bus.arr_we, 1);
        #2;
        nrst = 1'b0;
        #1;
        check("rst_drop_we", bus.arr_we, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_addr", bus.arr_addr, 0);
        check("rst_count", bus.count, 0);
        @(posedge clk);
        #3;
        arr_mode = 0;
        nrst     = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_out_valid", bus.out_valid, 0);
            check("post_rst_in_ready", bus.in_ready, 1);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        nrst          = 1'b0;
        bus.in_valid  = 1'b0;
        bus.len       = '0;
        bus.out_ready = 1'b0;
        bus.sIn       = '0;
        bus.sIn_valid = 1'b0;
        #12;
        check("reset_in_ready", bus.in_ready, 0);
        check("reset_out_valid", bus.out_valid, 0);
        check("reset_sin_ready", bus.sIn_ready, 0);
        check("reset_arr_we", bus.arr_we, 0);
        check("reset_arr_valid", bus.arr_valid, 0);
        check("reset_arr_addr", bus.arr_addr, 0);
        check("reset_arr_di", bus.arr_di, 0);
        check("reset_count", bus.count, 0);
        @(negedge clk);
        nrst = 1'b1;
        #1;
        check("release_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;

        // Continuous 16-word burst, exact latency.
        run_req(16, 1'b0, 0, 1'b1, 0, 1'b1, 1'b0);
        // Zero-length request: no writes, result next cycle.
        run_req(0, 1'b0, 0, 1'b1, 0, 1'b1, 1'b0);
        // Array ready toggling, gappy stream.
        run_req(8, 1'b0, 1, 1'b0, 0, 1'b0, 1'b0);
        // Full array: 256 writes, address wraps to 0.
        run_req(256, 1'b0, 0, 1'b1, 0, 1'b1, 1'b0);
        // Reset in the middle of a transfer, then a fresh short request.
        reset_mid_run();
        check("queue_clear_after_rst", exp_wr.size(), 0);
        run_req(3, 1'b1, 0, 1'b1, 0, 1'b1, 1'b0);
        // Result held for 10 cycles, released together with a new request.
        run_req(4, 1'b1, 0, 1'b1, 10, 1'b0, 1'b1);
        // Randomized mix.
        for (int r = 0; r < 8; r++) begin
            int n;
            int m;
            n = $urandom_range(1, 24);
            m = $urandom_range(0, 2);
            run_req(n, 1'b1, m, ($urandom_range(0, 1) == 1), $urandom_range(0, 3),
                    1'b0, 1'b0);
        end

        repeat (3) @(posedge clk);
        check("writes_outstanding", exp_wr.size(), 0);
        check("results_outstanding", exp_cnt.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_io_stream_write_array
